// File: rtl/regbank_mp_pkg.sv
// Shared bank-select codes and clear-engine state encoding for regbank_mp.
package regbank_mp_pkg;
  localparam logic [1:0] S_REGS = 2'd0;
  localparam logic [1:0] P_REGS = 2'd1;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;
endpackage

// File: rtl/regbank_mp_port_read.sv
// One combinational read port: bank decode, write bypass with higher-port priority,
// and busy masking so rd_busy agrees with the bypassed data.
module regbank_port_read import regbank_mp_pkg::*; #(
  parameter int WIDTH         = 32,
  parameter int NUM_REGS      = 16,
  parameter int NUM_PRED_REGS = 8,
  parameter int NUM_WR        = 2,
  parameter int REG_SEL       = $clog2(NUM_REGS)
) (
  input  logic [1:0]                          sel,
  input  logic [REG_SEL-1:0]                  addr,
  input  logic [NUM_REGS-1:0][WIDTH-1:0]      s_regs,
  input  logic [NUM_REGS-1:0]                 s_busy,
  input  logic [NUM_PRED_REGS-1:0]            p_regs,
  input  logic [NUM_PRED_REGS-1:0]            p_busy,
  input  logic [NUM_WR-1:0]                   wr_act,
  input  logic [NUM_WR-1:0][1:0]              wr_sel,
  input  logic [NUM_WR-1:0][REG_SEL-1:0]      wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]        wr_data,
  output logic [WIDTH-1:0]                    data,
  output logic                                busy
);
  localparam int PSEL = $clog2(NUM_PRED_REGS);

  logic [PSEL-1:0] paddr;
  assign paddr = addr[PSEL-1:0];

  // Ascending scan so the highest-indexed matching write port overrides.
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (sel == S_REGS) begin
      data = s_regs[addr];
      busy = s_busy[addr];
      for (int w = 0; w < NUM_WR; w++)
        if (wr_act[w] && wr_sel[w] == S_REGS && wr_addr[w] == addr) begin
          data = wr_data[w];
          busy = 1'b0;
        end
    end else if (sel == P_REGS) begin
      data = WIDTH'(p_regs[paddr]);
      busy = p_busy[paddr];
      for (int w = 0; w < NUM_WR; w++)
        if (wr_act[w] && wr_sel[w] == P_REGS && wr_addr[w][PSEL-1:0] == paddr) begin
          data = WIDTH'(wr_data[w][0]);
          busy = 1'b0;
        end
    end
  end
endmodule

// File: rtl/regbank_mp.sv
// Multi-port scalar/predicate register bank with bypass, busy scoreboard
// and a sequenced bank-clear engine.
module regbank_mp import regbank_mp_pkg::*; #(
  parameter int WIDTH         = 32,
  parameter int NUM_REGS      = 16,
  parameter int NUM_PRED_REGS = 8,
  parameter int NUM_RD        = 3,
  parameter int NUM_WR        = 2,
  parameter int REG_SEL       = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_RD-1:0][1:0]         rd_sel,
  input  logic [NUM_RD-1:0][REG_SEL-1:0] rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][1:0]         wr_sel,
  input  logic [NUM_WR-1:0][REG_SEL-1:0] wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]   wr_data,
  input  logic                           iss_valid,
  input  logic [1:0]                     iss_sel,
  input  logic [REG_SEL-1:0]             iss_addr,
  input  logic                           clear_req,
  output logic                           clear_busy,
  output logic                           clear_done
);
  localparam int PSEL = $clog2(NUM_PRED_REGS);

  logic [NUM_REGS-1:0][WIDTH-1:0] s_regs;
  logic [NUM_REGS-1:0]            s_busy;
  logic [NUM_PRED_REGS-1:0]       p_regs;
  logic [NUM_PRED_REGS-1:0]       p_busy;
  logic [REG_SEL-1:0]             cnt;
  clr_state_e                     state;
  logic                           sweep;
  logic [NUM_WR-1:0]              wr_act;

  assign sweep      = (state == CLR_SWEEP);
  assign clear_busy = sweep;
  assign clear_done = (state == CLR_DONE);
  // Writes are dropped during the sweep and held off while reset is asserted,
  // which also keeps the bypass from leaking data onto rd_data in either case.
  assign wr_act     = (sweep || !reset_n) ? '0 : wr_en;

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    regbank_port_read #(
      .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .NUM_PRED_REGS(NUM_PRED_REGS),
      .NUM_WR(NUM_WR), .REG_SEL(REG_SEL)
    ) u_rd (
      .sel(rd_sel[r]), .addr(rd_addr[r]),
      .s_regs(s_regs), .s_busy(s_busy), .p_regs(p_regs), .p_busy(p_busy),
      .wr_act(wr_act), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .data(rd_data[r]), .busy(rd_busy[r])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_regs <= '0;
      s_busy <= '0;
      p_regs <= '0;
      p_busy <= '0;
      cnt    <= '0;
      state  <= CLR_IDLE;
    end else if (sweep) begin
      s_regs[cnt] <= '0;
      s_busy[cnt] <= 1'b0;
      if (cnt == '0) begin
        p_regs <= '0;
        p_busy <= '0;
      end
      if (cnt == REG_SEL'(NUM_REGS-1)) state <= CLR_DONE;
      else                              cnt   <= cnt + 1'b1;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wr_sel[w] == S_REGS) begin
          s_regs[wr_addr[w]] <= wr_data[w];
          s_busy[wr_addr[w]] <= 1'b0;
        end else if (wr_en[w] && wr_sel[w] == P_REGS) begin
          p_regs[wr_addr[w][PSEL-1:0]] <= wr_data[w][0];
          p_busy[wr_addr[w][PSEL-1:0]] <= 1'b0;
        end
      end
      // Issued after the writes so a new producer outranks a same-cycle writeback.
      if (iss_valid && iss_sel == S_REGS)      s_busy[iss_addr]           <= 1'b1;
      else if (iss_valid && iss_sel == P_REGS) p_busy[iss_addr[PSEL-1:0]] <= 1'b1;
      if (state == CLR_DONE) state <= CLR_IDLE;
      else if (clear_req) begin
        state <= CLR_SWEEP;
        cnt   <= '0;
      end
    end
  end
endmodule
